// File: rtl/float_add_arbiter.sv
// Round-robin share of one LAT-deep FP adder among N requesters; a result returns LAT+1 edges after its grant, and responses cannot be backpressured.
// Optional macro FADD_ARB_SUB_EN adds req_sub: a granted request with req_sub set computes a-b by inverting B's sign bit.
module float_add_arbiter #(
  parameter int E_BIT = 8,
  parameter int F_BIT = 23,
  parameter int N     = 4,
  parameter int ID_W  = (N > 1) ? $clog2(N) : 1,
  parameter int LAT   = 3,
  localparam int W    = E_BIT + F_BIT + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
`ifdef FADD_ARB_SUB_EN
  input  logic [N-1:0]    req_sub,
`endif
  output logic [N-1:0]    req_ready,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  input  logic [W-1:0]    add_out,
  output logic            resp_valid,
  output logic [ID_W-1:0] resp_id,
  output logic [W-1:0]    resp_data,
  output logic            busy
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  tag_t [LAT:0]    tag_q, tag_d;
  logic            resp_vld_q, resp_vld_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [W-1:0]    resp_dat_q, resp_dat_d;

  logic [N-1:0]    grant;
  logic [ID_W-1:0] win_id;
  logic            xfer;
  logic [W-1:0]    win_a, win_b;
  logic            busy_c;

  // Scan from farthest to nearest so the first valid index after ptr_q wins.
  always_comb begin
    int idx;
    grant  = '0;
    win_id = '0;
    idx    = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        win_id     = ID_W'(idx);
      end
    end
  end

  assign req_ready = (en && rst_n) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    win_a = req_a[int'(win_id)*W +: W];
    win_b = req_b[int'(win_id)*W +: W];
`ifdef FADD_ARB_SUB_EN
    win_b[W-1] = win_b[W-1] ^ req_sub[win_id];
`endif
  end

  always_comb begin
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (xfer) begin
      ptr_d   = win_id;
      add_a_d = win_a;
      add_b_d = win_b;
    end
  end

  // Tag stage LAT lines up with add_out for the same operand pair.
  always_comb begin
    tag_d        = '0;
    tag_d[0].vld = xfer;
    tag_d[0].id  = win_id;
    for (int k = 1; k <= LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    resp_vld_d = tag_q[LAT].vld;
    resp_id_d  = resp_id_q;
    resp_dat_d = resp_dat_q;
    if (tag_q[LAT].vld) begin
      resp_id_d  = tag_q[LAT].id;
      resp_dat_d = add_out;
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      busy_c = busy_c | tag_q[k].vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= ID_W'(N - 1);
      add_a_q    <= '0;
      add_b_q    <= '0;
      tag_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_id_q  <= '0;
      resp_dat_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      tag_q      <= tag_d;
      resp_vld_q <= resp_vld_d;
      resp_id_q  <= resp_id_d;
      resp_dat_q <= resp_dat_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_vld_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_dat_q;
  assign busy       = busy_c;

endmodule

// File: tb/tb_float_add_arbiter.sv
// Directed and randomised bench for float_add_arbiter with a 3-stage adder model.
// An issue-order scoreboard predicts grants, operands, busy and each response.
module tb_float_add_arbiter;
  localparam int E_BIT = 8;
  localparam int F_BIT = 23;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int LAT   = 3;
  localparam int W     = 32;
`ifdef FADD_ARB_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  typedef struct {
    int           id;
    logic [W-1:0] dat;
    int           due;
  } rec_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            en    = 1'b0;
  logic [N-1:0]    tv    = '0;
  logic [N-1:0]    tsub  = '0;
  logic [N-1:0]    auto_mask = '0;
  logic            rand_mode = 1'b0;
  logic [W-1:0]    opa [N];
  logic [W-1:0]    opb [N];
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    add_a, add_b, add_out;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [W-1:0]    resp_data;
  logic            busy;
  logic [W-1:0]    pipe [LAT];

  rec_t         q[$];
  int           grants[$];
  int           last = N - 1;
  int           cyc  = 0;
  int           vec  = 0;
  int           errs = 0;
  logic [W-1:0] exp_a = '0;
  logic [W-1:0] exp_b = '0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  end

  float_add_arbiter #(.E_BIT(E_BIT), .F_BIT(F_BIT), .N(N), .ID_W(ID_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(tv), .req_a(req_a), .req_b(req_b),
`ifdef FADD_ARB_SUB_EN
    .req_sub(tsub),
`endif
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Shared adder stand-in: LAT registered stages, reset with the arbiter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fadd(add_a, add_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign add_out = pipe[LAT-1];

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  function automatic int model_grant();
    if (!en || !rst_n) return -1;
    for (int k = 1; k <= N; k++)
      if (tv[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_ops(input int i);
    opa[i] = rnd_op();
    opb[i] = rnd_op();
    if (SUB_ON) tsub[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    int           g;
    logic [N-1:0] er;
    logic         bexp;
    logic [W-1:0] bb;
    rec_t         r;
    @(negedge clk);
    g  = model_grant();
    er = (g < 0) ? '0 : (N'(1) << g);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("add_a", 64'(add_a), 64'(exp_a));
    chk("add_b", 64'(add_b), 64'(exp_b));
    bexp = 1'b0;
    foreach (q[i]) if (q[i].due > cyc) bexp = 1'b1;
    chk("busy", 64'(busy), 64'(bexp));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("resp_valid", 64'(resp_valid), 64'(1));
      chk("resp_id", 64'(resp_id), 64'(q[0].id));
      chk("resp_data", 64'(resp_data), 64'(q[0].dat));
      void'(q.pop_front());
    end else begin
      chk("resp_idle", 64'(resp_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      bb    = opb[g] ^ ((SUB_ON && tsub[g]) ? 32'h8000_0000 : 32'h0);
      r.id  = g;
      r.dat = fadd(opa[g], bb);
      r.due = cyc + LAT + 1;
      q.push_back(r);
      exp_a = opa[g];
      exp_b = bb;
      last  = g;
      grants.push_back(g);
      if (auto_mask[g]) new_ops(g);
      else tv[g] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!tv[i] && $urandom_range(0, 1) == 1) begin new_ops(i); tv[i] = 1'b1; end
      en = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_add_a", 64'(add_a), 64'(0));
    chk("rst_add_b", 64'(add_b), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    q.delete();
    grants.delete();
    last = N - 1; exp_a = '0; exp_b = '0;
    tv = '0; tsub = '0; auto_mask = '0; en = 1'b0; rand_mode = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int t_last, fall, nresp;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    #2;
    apply_reset();

    // Single add from requester 2: 1.0 + 2.0.
    en = 1'b1;
    opa[2] = 32'h3F80_0000; opb[2] = 32'h4000_0000; tv[2] = 1'b1;
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    repeat (6) step();
    chk("single_id", 64'(resp_id), 64'(2));
    chk("single_data", 64'(resp_data), 64'(32'h4040_0000));

    // Full contention from reset.
    apply_reset();
    en = 1'b1; tv = '1; auto_mask = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (8) step();
    for (int k = 0; k < 8; k++) chk("contend_grant", 64'(grants[k]), 64'(k % 4));
    tv = '0; auto_mask = '0;
    repeat (6) step();

    // Fairness between requesters 1 and 3.
    apply_reset();
    en = 1'b1; tv = 4'b1010; auto_mask = 4'b1010;
    new_ops(1); new_ops(3);
    repeat (8) step();
    for (int k = 0; k < 8; k++) chk("fair_grant", 64'(grants[k]), 64'((k % 2 == 0) ? 1 : 3));
    tv = '0; auto_mask = '0;
    repeat (6) step();

    // Drain after three issues.
    apply_reset();
    en = 1'b1; tv = '1; auto_mask = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (3) step();
    t_last = cyc;
    auto_mask = '0;
    en = 1'b0;
    #1;
    chk("drain_ready_off", 64'(req_ready), 64'(0));
    fall = -1; nresp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid) nresp++;
      if (fall < 0 && !busy) fall = cyc - t_last;
    end
    chk("drain_busy_fall", 64'(fall), 64'(4));
    chk("drain_resps", 64'(nresp), 64'(3));
    tv = '0;

    // Reset two cycles after an issue.
    apply_reset();
    en = 1'b1; new_ops(1); tv[1] = 1'b1;
    repeat (3) step();
    apply_reset();
    en = 1'b1; nresp = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (resp_valid) nresp++;
    end
    chk("reset_no_resp", 64'(nresp), 64'(0));

`ifdef FADD_ARB_SUB_EN
    // 3.0 - 1.0 through the sign flip.
    apply_reset();
    en = 1'b1;
    opa[0] = 32'h4040_0000; opb[0] = 32'h3F80_0000; tsub[0] = 1'b1; tv[0] = 1'b1;
    repeat (6) step();
    chk("sub_data", 64'(resp_data), 64'(32'h4000_0000));
`endif

    // Randomised traffic with en toggling.
    apply_reset();
    en = 1'b1; rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0; tv = '0; en = 1'b1;
    repeat (6) step();
    chk("rand_drained", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
